decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second pipeline stage of the flat RV32I core; sits directly downstream of the fetch stage.
- Consumes the registered PC/instruction pair and its valid bit.
- Decodes fields and immediates and reads the 32x32 register file, with a write port driven from writeback.
- Detects load-use hazards and returns back-pressure (ready/stall) to fetch; registers all results into the ID/EX pipeline register for the execute stage.

Parameters:
- XLEN, 32, datapath width (fixed; instruction width is always 32).
- NREG, 32, number of architectural registers; x0 hardwired to zero.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- PC_in  input  32  PC from fetch.
- IR_in  input  32  instruction from fetch.
- v_in  input  1  fetch output valid.
- r_out  output  1  ready to fetch (drives fetch r_in); combinational.
- stall_out  output  1  to fetch stall input; combinational.
- r_in  input  1  execute stage ready.
- flush  input  1  taken branch/jump resolved in EX (COMP_alu & valid).
- EX_load  input  1  instruction currently in EX is a valid load.
- EX_rd  input  5  destination of instruction in EX.
- WB_en  input  1  register-file write enable.
- WB_rd  input  5  write address.
- WB_data  input  32  write data.
- v_out  output  1  ID/EX valid.
- PC_out  output  32  registered PC.
- IR_out  output  32  registered raw instruction.
- RS1_val  output  32  registered rs1 operand.
- RS2_val  output  32  registered rs2 operand.
- IMM_out  output  32  registered sign-extended immediate.
- RD_out  output  5  registered destination register.
- OPC_out  output  7  registered opcode IR[6:0].
- F3_out  output  3  registered funct3.
- F7b5_out  output  1  registered IR[30].

Behaviour:
- Reset (rst=1 at posedge): v_out=0; all data outputs=0; all 32 registers cleared to 0. Reset overrides flush, writes and handshakes.
- Field extraction from IR_in: rs1=IR[19:15], rs2=IR[24:20], rd=IR[11:7].
- Immediate by opcode:
  - I-type (0010011, 0000011, 1100111): sext IR[31:20].
  - S (0100011): sext {IR[31:25],IR[11:7]}.
  - B (1100011): sext {IR[31],IR[7],IR[30:25],IR[11:8],0}.
  - U (0110111, 0010111): {IR[31:12],12'b0}.
  - J (1101111): sext {IR[31],IR[19:12],IR[20],IR[30:21],0}.
  - Any other opcode: 0.
- Operand usage:
  - uses_rs1 for all opcodes except 0110111, 0010111, 1101111.
  - uses_rs2 only for 1100011, 0100011, 0110011.
- Register file:
  - Write at posedge when WB_en & WB_rd!=0; writes to x0 are ignored.
  - Read is combinational with write-through bypass: if WB_en & WB_rd==rsN & rsN!=0, the operand is WB_data.
  - Reads of x0 always return 0.
- Hazard: hazard = v_in & EX_load & EX_rd!=0 & ((uses_rs1 & rs1==EX_rd) | (uses_rs2 & rs2==EX_rd)).
- Back-pressure (combinational):
  - out_free = ~v_out | r_in.
  - r_out = out_free & ~hazard.
  - stall_out = ~r_out.
- Accept: accept = v_in & r_out & ~flush.
- ID/EX register update at posedge, in priority order:
  1. rst.
  2. flush: v_out<=0 and the incoming instruction is discarded.
  3. accept: all outputs load; v_out<=1.
  4. out_free & ~accept (hazard or no input): v_out<=0, inserting a bubble; data outputs may update but are don't-care.
  5. Otherwise (~out_free): all outputs hold.
- Latency: one cycle from accept to v_out=1.
- Hazard bubble: exactly one cycle per load-use hazard. The next cycle EX_load drops because the load has advanced, and the held instruction is accepted.
- Simultaneous WB write and read of the same register: the new data is delivered (bypass).
- Simultaneous flush and hazard: flush wins; v_out<=0; r_out still follows the formula above.
- Reset mid-stall: v_out cleared; r_out=1 on the following cycle when v_in=0 or there is no hazard.

Test Plan:
- Reset, then IR_in=0x00500093 (addi x1,x0,5), PC_in=0x0, v_in=1, r_in=1 -> next cycle v_out=1, IMM_out=5, RD_out=1, RS1_val=0, OPC_out=0x13.
- WB_en=1, WB_rd=2, WB_data=0xDEADBEEF in the same cycle as IR_in=0x00210233 (add x4,x2,x2) -> RS1_val=RS2_val=0xDEADBEEF; a later WB to x0 leaves x0 reading 0.
- EX_load=1, EX_rd=3, IR_in=0x003081B3 (add x3,x1,x3) -> r_out=0, stall_out=1, next v_out=0. After EX_load drops: accept, v_out=1.
- Immediate formats:
  - IR_in=0xFE000EE3 (beq, offset -4) -> IMM_out=0xFFFFFFFC.
  - 0x123452B7 (lui) -> IMM_out=0x12345000.
  - 0xFF5FF0EF (jal -12) -> IMM_out=0xFFFFFFF4.
- v_out=1, r_in=0 for 3 cycles -> outputs hold, r_out=0. Then r_in=1 -> new instruction loads next edge.
- flush=1 with v_in=1 -> v_out=0 next cycle. rst asserted while stalled -> v_out=0 and all registers read 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch/decode/execute-facing signals of the RV32I decode stage.
// The master modport drives the stage and the slave modport is the stage itself.
interface decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] PC_in;
    logic [31:0]     IR_in;
    logic            v_in;
    logic            r_out;
    logic            stall_out;
    logic            r_in;
    logic            flush;
    logic            EX_load;
    logic [4:0]      EX_rd;
    logic            WB_en;
    logic [4:0]      WB_rd;
    logic [XLEN-1:0] WB_data;
    logic            v_out;
    logic [XLEN-1:0] PC_out;
    logic [31:0]     IR_out;
    logic [XLEN-1:0] RS1_val;
    logic [XLEN-1:0] RS2_val;
    logic [XLEN-1:0] IMM_out;
    logic [4:0]      RD_out;
    logic [6:0]      OPC_out;
    logic [2:0]      F3_out;
    logic            F7b5_out;

    modport master (
        output PC_in, IR_in, v_in, r_in, flush, EX_load, EX_rd, WB_en, WB_rd, WB_data,
        input  r_out, stall_out, v_out, PC_out, IR_out, RS1_val, RS2_val, IMM_out,
        input  RD_out, OPC_out, F3_out, F7b5_out
    );

    modport slave (
        input  PC_in, IR_in, v_in, r_in, flush, EX_load, EX_rd, WB_en, WB_rd, WB_data,
        output r_out, stall_out, v_out, PC_out, IR_out, RS1_val, RS2_val, IMM_out,
        output RD_out, OPC_out, F3_out, F7b5_out
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, register file with WB bypass,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;

    logic [XLEN-1:0] regs_q [NREG];

    logic [31:0]     ir;
    logic [6:0]      opc;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm;
    logic            uses_rs1, uses_rs2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            hazard, out_free, r_out, accept;

    logic            v_q;
    logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
    logic [31:0]     ir_q;
    logic [4:0]      rd_q;
    logic [6:0]      opc_q;
    logic [2:0]      f3_q;
    logic            f7b5_q;

    assign ir  = bus.IR_in;
    assign opc = ir[6:0];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign rd  = ir[11:7];

    always_comb begin
        imm = '0;
        case (opc)
            OpImm, OpLoad, OpJalr: imm = {{20{ir[31]}}, ir[31:20]};
            OpStore:               imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OpBranch:              imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OpLui, OpAuipc:        imm = {ir[31:12], 12'b0};
            OpJal:                 imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:               imm = '0;
        endcase
    end

    assign uses_rs1 = !(opc == OpLui || opc == OpAuipc || opc == OpJal);
    assign uses_rs2 = (opc == OpBranch || opc == OpStore || opc == OpReg);

    // Write-through: a same-cycle writeback to the source register wins over the array.
    always_comb begin
        rs1_val = regs_q[rs1];
        rs2_val = regs_q[rs2];
        if (bus.WB_en && bus.WB_rd == rs1) rs1_val = bus.WB_data;
        if (bus.WB_en && bus.WB_rd == rs2) rs2_val = bus.WB_data;
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end

    assign hazard = bus.v_in && bus.EX_load && (bus.EX_rd != 5'd0) &&
                    ((uses_rs1 && rs1 == bus.EX_rd) || (uses_rs2 && rs2 == bus.EX_rd));

    assign out_free = !v_q || bus.r_in;
    assign r_out    = out_free && !hazard;
    assign accept   = bus.v_in && r_out && !bus.flush;

    assign bus.r_out     = r_out;
    assign bus.stall_out = !r_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (bus.WB_en && bus.WB_rd != 5'd0) begin
            regs_q[bus.WB_rd] <= bus.WB_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            pc_q   <= '0;
            ir_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            imm_q  <= '0;
            rd_q   <= '0;
            opc_q  <= '0;
            f3_q   <= '0;
            f7b5_q <= 1'b0;
        end else if (bus.flush) begin
            v_q <= 1'b0;
        end else if (accept) begin
            v_q    <= 1'b1;
            pc_q   <= bus.PC_in;
            ir_q   <= ir;
            rs1_q  <= rs1_val;
            rs2_q  <= rs2_val;
            imm_q  <= imm;
            rd_q   <= rd;
            opc_q  <= opc;
            f3_q   <= ir[14:12];
            f7b5_q <= ir[30];
        end else if (out_free) begin
            // Bubble: data fields hold, only valid drops.
            v_q <= 1'b0;
        end
    end

    assign bus.v_out    = v_q;
    assign bus.PC_out   = pc_q;
    assign bus.IR_out   = ir_q;
    assign bus.RS1_val  = rs1_q;
    assign bus.RS2_val  = rs2_q;
    assign bus.IMM_out  = imm_q;
    assign bus.RD_out   = rd_q;
    assign bus.OPC_out  = opc_q;
    assign bus.F3_out   = f3_q;
    assign bus.F7b5_out = f7b5_q;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table plus hand-written
// bypass, hazard, back-pressure, flush and reset sequences.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    decode_stage_if bus ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7b5;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.PC_in   = '0;
        bus.IR_in   = '0;
        bus.v_in    = 1'b0;
        bus.r_in    = 1'b1;
        bus.flush   = 1'b0;
        bus.EX_load = 1'b0;
        bus.EX_rd   = '0;
        bus.WB_en   = 1'b0;
        bus.WB_rd   = '0;
        bus.WB_data = '0;
    endtask

    task automatic issue(input logic [31:0] ir, input logic [31:0] pc);
        bus.IR_in = ir;
        bus.PC_in = pc;
        bus.v_in  = 1'b1;
    endtask

    initial begin
        vecs[0] = '{32'h00500093, 32'h0000_0000, 32'h0000_0005, 5'd1,  7'h13, 3'd0, 1'b0};
        vecs[1] = '{32'hFE000EE3, 32'h0000_0004, 32'hFFFF_FFFC, 5'd29, 7'h63, 3'd0, 1'b1};
        vecs[2] = '{32'h123452B7, 32'h0000_0008, 32'h1234_5000, 5'd5,  7'h37, 3'd5, 1'b0};
        vecs[3] = '{32'hFF5FF0EF, 32'h0000_000C, 32'hFFFF_FFF4, 5'd1,  7'h6F, 3'd7, 1'b1};
        vecs[4] = '{32'hFE112E23, 32'h0000_0010, 32'hFFFF_FFFC, 5'd28, 7'h23, 3'd2, 1'b1};
        vecs[5] = '{32'hFFFFFFFF, 32'h0000_0014, 32'h0000_0000, 5'd31, 7'h7F, 3'd7, 1'b1};
        vecs[6] = '{32'hFFFFF517, 32'h0000_0018, 32'hFFFF_F000, 5'd10, 7'h17, 3'd7, 1'b1};
        vecs[7] = '{32'hFFF32283, 32'h0000_001C, 32'hFFFF_FFFF, 5'd5,  7'h03, 3'd2, 1'b1};

        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("reset v_out", 32'(bus.v_out), 32'd0);
        chk("reset IR_out", bus.IR_out, 32'd0);
        chk("reset IMM_out", bus.IMM_out, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle r_out", 32'(bus.r_out), 32'd1);
        chk("idle stall_out", 32'(bus.stall_out), 32'd0);

        // Decode table; the register file is still all zero here.
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].ir, vecs[i].pc);
            tick();
            chk($sformatf("vec%0d v_out", i), 32'(bus.v_out), 32'd1);
            chk($sformatf("vec%0d PC_out", i), bus.PC_out, vecs[i].pc);
            chk($sformatf("vec%0d IR_out", i), bus.IR_out, vecs[i].ir);
            chk($sformatf("vec%0d IMM_out", i), bus.IMM_out, vecs[i].imm);
            chk($sformatf("vec%0d RD_out", i), 32'(bus.RD_out), 32'(vecs[i].rd));
            chk($sformatf("vec%0d OPC_out", i), 32'(bus.OPC_out), 32'(vecs[i].opc));
            chk($sformatf("vec%0d F3_out", i), 32'(bus.F3_out), 32'(vecs[i].f3));
            chk($sformatf("vec%0d F7b5_out", i), 32'(bus.F7b5_out), 32'(vecs[i].f7b5));
            chk($sformatf("vec%0d RS1_val", i), bus.RS1_val, 32'd0);
        end

        // Writeback bypass, then readback from the array, then x0 write ignored.
        issue(32'h00210233, 32'h100);
        bus.WB_en = 1'b1; bus.WB_rd = 5'd2; bus.WB_data = 32'hDEADBEEF;
        tick();
        chk("bypass RS1_val", bus.RS1_val, 32'hDEADBEEF);
        chk("bypass RS2_val", bus.RS2_val, 32'hDEADBEEF);
        bus.WB_en = 1'b0;
        tick();
        chk("stored RS1_val", bus.RS1_val, 32'hDEADBEEF);
        bus.WB_en = 1'b1; bus.WB_rd = 5'd0; bus.WB_data = 32'h12345678;
        issue(32'h00000033, 32'h104);
        tick();
        chk("x0 bypass RS1_val", bus.RS1_val, 32'd0);
        bus.WB_en = 1'b0;
        tick();
        chk("x0 stored RS2_val", bus.RS2_val, 32'd0);

        // Load-use hazard on rs2=x3: one bubble then accept.
        bus.EX_load = 1'b1; bus.EX_rd = 5'd3;
        issue(32'h003081B3, 32'h200);
        #1;
        chk("hazard r_out", 32'(bus.r_out), 32'd0);
        chk("hazard stall_out", 32'(bus.stall_out), 32'd1);
        tick();
        chk("hazard bubble v_out", 32'(bus.v_out), 32'd0);
        bus.EX_load = 1'b0;
        #1;
        chk("post-hazard r_out", 32'(bus.r_out), 32'd1);
        tick();
        chk("post-hazard v_out", 32'(bus.v_out), 32'd1);
        chk("post-hazard IR_out", bus.IR_out, 32'h003081B3);

        // lui does not read rs1/rs2, so a load to x3 in EX is no hazard.
        bus.EX_load = 1'b1; bus.EX_rd = 5'd3;
        issue(32'h123451B7, 32'h204);
        #1;
        chk("lui no-hazard r_out", 32'(bus.r_out), 32'd1);
        bus.EX_rd = 5'd0;
        issue(32'h00000033, 32'h208);
        #1;
        chk("EX_rd x0 no-hazard r_out", 32'(bus.r_out), 32'd1);
        bus.EX_load = 1'b0;
        tick();

        // Back-pressure: hold outputs while r_in=0.
        issue(32'h00500093, 32'h300);
        tick();
        bus.r_in = 1'b0;
        issue(32'h123452B7, 32'h304);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d r_out", c), 32'(bus.r_out), 32'd0);
            tick();
            chk($sformatf("stall%0d v_out", c), 32'(bus.v_out), 32'd1);
            chk($sformatf("stall%0d PC_out", c), bus.PC_out, 32'h300);
        end
        bus.r_in = 1'b1;
        #1;
        chk("release r_out", 32'(bus.r_out), 32'd1);
        tick();
        chk("release PC_out", bus.PC_out, 32'h304);
        chk("release IMM_out", bus.IMM_out, 32'h12345000);

        // Flush discards the incoming instruction.
        issue(32'h00500093, 32'h400);
        bus.flush = 1'b1;
        #1;
        chk("flush r_out", 32'(bus.r_out), 32'd1);
        tick();
        chk("flush v_out", 32'(bus.v_out), 32'd0);
        chk("flush PC_out held", bus.PC_out, 32'h304);

        // Flush with hazard: flush wins, r_out still follows the hazard.
        bus.EX_load = 1'b1; bus.EX_rd = 5'd3;
        issue(32'h003081B3, 32'h404);
        #1;
        chk("flush+hazard r_out", 32'(bus.r_out), 32'd0);
        tick();
        chk("flush+hazard v_out", 32'(bus.v_out), 32'd0);
        bus.flush = 1'b0; bus.EX_load = 1'b0;

        // Reset while stalled clears valid and the register file.
        issue(32'h00500093, 32'h500);
        tick();
        bus.r_in = 1'b0;
        issue(32'h00210233, 32'h504);
        rst = 1'b1;
        tick();
        chk("rst-stall v_out", 32'(bus.v_out), 32'd0);
        chk("rst-stall PC_out", bus.PC_out, 32'd0);
        rst = 1'b0;
        bus.v_in = 1'b0;
        #1;
        chk("rst-stall r_out", 32'(bus.r_out), 32'd1);
        bus.r_in = 1'b1;
        issue(32'h00210233, 32'h508);
        tick();
        chk("rst cleared x2 RS1_val", bus.RS1_val, 32'd0);
        chk("rst cleared x2 RS2_val", bus.RS2_val, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
